// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller and the datapath muxes it steers.
// The memtoReg and forward-select codes must match what the datapath decodes,
// so both sides import them from here rather than redefining them.
package hazard_ctrl_pkg;

    // memtoReg field carried down the pipe with each instruction
    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

    // EX operand source select
    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_PC4 = 2'b11;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'b00,
        HZ_LOAD_STALL = 2'b01,
        HZ_MEM_WAIT   = 2'b10
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forward-source selector for one EX ALU operand (combinational).
// Ports:
//   i_read_addr       register index read by the EX operand
//   i_mem_write_addr  rd held in EX/MEM
//   i_mem_reg_write   regWrite held in EX/MEM
//   i_mem_memto_reg   memtoReg held in EX/MEM
//   i_wb_write_addr   rd held in MEM/WB
//   i_wb_reg_write    regWrite held in MEM/WB
//   o_forward         operand source code (FWD_*)
import hazard_ctrl_pkg::*;

module fwd_select #(
    parameter int REG_IDX_WIDTH = 5
) (
    input  logic [REG_IDX_WIDTH-1:0] i_read_addr,
    input  logic [REG_IDX_WIDTH-1:0] i_mem_write_addr,
    input  logic                     i_mem_reg_write,
    input  logic [1:0]               i_mem_memto_reg,
    input  logic [REG_IDX_WIDTH-1:0] i_wb_write_addr,
    input  logic                     i_wb_reg_write,
    output logic [1:0]               o_forward
);

    logic w_mem_hit;
    logic w_wb_hit;

    // x0 is hardwired zero, so a write to it is never a forwarding source
    assign w_mem_hit = i_mem_reg_write && (i_mem_write_addr != '0) &&
                       (i_mem_write_addr == i_read_addr);
    assign w_wb_hit  = i_wb_reg_write && (i_wb_write_addr != '0) &&
                       (i_wb_write_addr == i_read_addr);

    always_comb begin
        o_forward = FWD_RF;
        if (w_mem_hit) begin
            // a jump-and-link in MEM carries PC+4, not the ALU result
            o_forward = (i_mem_memto_reg == MEMTOREG_PC4) ? FWD_MEM_PC4 : FWD_MEM_ALU;
        end else if (w_wb_hit) begin
            o_forward = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives stall/flush/freeze of PC, IF/ID and ID/EX,
// selects EX operand forwarding and counts load-use stalls and branch flushes.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   IDreadAddr1/2, IDuses1/2      source regs of the instruction in IF/ID
//   EXreadAddr1/2, EXwriteAddr    rs1/rs2/rd held in ID/EX
//   EXmemtoReg, EXbranchTaken     ID/EX load marker, EX redirect
//   MEMwriteAddr/regWrite/memtoReg, WBwriteAddr/regWrite   later-stage writers
//   memBusy                       data memory still busy with MEM access
//   PCStall, IFIDStall, IFIDFlush, IDEXFlush, freeze       pipe register control
//   forwardA/B                    EX operand source codes
//   stallCount, flushCount        wrapping event counters
//
// state         | meaning
// HZ_RUN        | normal issue, load-use detection active
// HZ_LOAD_STALL | one bubble just inserted; load-use detection masked
// HZ_MEM_WAIT   | data memory held the pipe last cycle
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
    parameter int REG_IDX_WIDTH = 5,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_IDX_WIDTH-1:0] IDreadAddr1,
    input  logic [REG_IDX_WIDTH-1:0] IDreadAddr2,
    input  logic                     IDuses1,
    input  logic                     IDuses2,
    input  logic [REG_IDX_WIDTH-1:0] EXreadAddr1,
    input  logic [REG_IDX_WIDTH-1:0] EXreadAddr2,
    input  logic [REG_IDX_WIDTH-1:0] EXwriteAddr,
    input  logic [1:0]               EXmemtoReg,
    input  logic                     EXbranchTaken,
    input  logic [REG_IDX_WIDTH-1:0] MEMwriteAddr,
    input  logic                     MEMregWrite,
    input  logic [1:0]               MEMmemtoReg,
    input  logic [REG_IDX_WIDTH-1:0] WBwriteAddr,
    input  logic                     WBregWrite,
    input  logic                     memBusy,
    output logic                     PCStall,
    output logic                     IFIDStall,
    output logic                     IFIDFlush,
    output logic                     IDEXFlush,
    output logic                     freeze,
    output logic [1:0]               forwardA,
    output logic [1:0]               forwardB,
    output logic [CNT_WIDTH-1:0]     stallCount,
    output logic [CNT_WIDTH-1:0]     flushCount
);

    hz_state_e            r_state;
    hz_state_e            w_next_state;
    logic [CNT_WIDTH-1:0] r_stall_count;
    logic [CNT_WIDTH-1:0] r_flush_count;
    logic                 w_load_use;
    logic                 w_stall_inc;
    logic                 w_flush_inc;
    logic [1:0]           w_fwd_a;
    logic [1:0]           w_fwd_b;

    assign w_load_use = (EXmemtoReg == MEMTOREG_MEM) && (EXwriteAddr != '0) &&
                        ((IDuses1 && (IDreadAddr1 == EXwriteAddr)) ||
                         (IDuses2 && (IDreadAddr2 == EXwriteAddr)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HZ_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority: memBusy > branch redirect > load-use. A branch squashes the
    // ID instruction, so a load-use hazard seen alongside it is irrelevant.
    always_comb begin
        w_next_state = HZ_RUN;
        PCStall      = 1'b0;
        IFIDStall    = 1'b0;
        IFIDFlush    = 1'b0;
        IDEXFlush    = 1'b0;
        freeze       = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        if (reset) begin
            w_next_state = HZ_RUN;
        end else if (memBusy) begin
            freeze       = 1'b1;
            w_next_state = HZ_MEM_WAIT;
        end else if (EXbranchTaken) begin
            IFIDFlush   = 1'b1;
            IDEXFlush   = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_load_use && (r_state != HZ_LOAD_STALL)) begin
            PCStall      = 1'b1;
            IFIDStall    = 1'b1;
            IDEXFlush    = 1'b1;
            w_stall_inc  = 1'b1;
            w_next_state = HZ_LOAD_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall_inc) r_stall_count <= r_stall_count + CNT_WIDTH'(1);
            if (w_flush_inc) r_flush_count <= r_flush_count + CNT_WIDTH'(1);
        end
    end

    fwd_select #(.REG_IDX_WIDTH(REG_IDX_WIDTH)) u_fwd_a (
        .i_read_addr      (EXreadAddr1),
        .i_mem_write_addr (MEMwriteAddr),
        .i_mem_reg_write  (MEMregWrite),
        .i_mem_memto_reg  (MEMmemtoReg),
        .i_wb_write_addr  (WBwriteAddr),
        .i_wb_reg_write   (WBregWrite),
        .o_forward        (w_fwd_a)
    );

    fwd_select #(.REG_IDX_WIDTH(REG_IDX_WIDTH)) u_fwd_b (
        .i_read_addr      (EXreadAddr2),
        .i_mem_write_addr (MEMwriteAddr),
        .i_mem_reg_write  (MEMregWrite),
        .i_mem_memto_reg  (MEMmemtoReg),
        .i_wb_write_addr  (WBwriteAddr),
        .i_wb_reg_write   (WBregWrite),
        .o_forward        (w_fwd_b)
    );

    assign forwardA   = reset ? FWD_RF : w_fwd_a;
    assign forwardB   = reset ? FWD_RF : w_fwd_b;
    assign stallCount = r_stall_count;
    assign flushCount = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Counters are built 3 bits wide so that
// wrap-around is reached in a handful of events.
module tb_hazard_ctrl;

    localparam int R = 5;
    localparam int C = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [R-1:0] IDreadAddr1, IDreadAddr2, EXreadAddr1, EXreadAddr2, EXwriteAddr;
    logic [R-1:0] MEMwriteAddr, WBwriteAddr;
    logic         IDuses1, IDuses2, EXbranchTaken, MEMregWrite, WBregWrite, memBusy;
    logic [1:0]   EXmemtoReg, MEMmemtoReg;
    logic         PCStall, IFIDStall, IFIDFlush, IDEXFlush, freeze;
    logic [1:0]   forwardA, forwardB;
    logic [C-1:0] stallCount, flushCount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_IDX_WIDTH(R), .CNT_WIDTH(C)) dut (
        .clk(clk), .reset(reset),
        .IDreadAddr1(IDreadAddr1), .IDreadAddr2(IDreadAddr2),
        .IDuses1(IDuses1), .IDuses2(IDuses2),
        .EXreadAddr1(EXreadAddr1), .EXreadAddr2(EXreadAddr2),
        .EXwriteAddr(EXwriteAddr), .EXmemtoReg(EXmemtoReg),
        .EXbranchTaken(EXbranchTaken),
        .MEMwriteAddr(MEMwriteAddr), .MEMregWrite(MEMregWrite), .MEMmemtoReg(MEMmemtoReg),
        .WBwriteAddr(WBwriteAddr), .WBregWrite(WBregWrite),
        .memBusy(memBusy),
        .PCStall(PCStall), .IFIDStall(IFIDStall), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .freeze(freeze),
        .forwardA(forwardA), .forwardB(forwardB),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {PCStall, IFIDStall, IFIDFlush, IDEXFlush, freeze}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, PCStall, IFIDStall, IFIDFlush, IDEXFlush, freeze}, {27'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
        chk({tag, "_stall"}, {29'd0, stallCount}, s[31:0]);
        chk({tag, "_flush"}, {29'd0, flushCount}, f[31:0]);
    endtask

    task automatic clr();
        IDreadAddr1 = '0; IDreadAddr2 = '0; IDuses1 = 0; IDuses2 = 0;
        EXreadAddr1 = '0; EXreadAddr2 = '0; EXwriteAddr = '0; EXmemtoReg = 2'b00;
        EXbranchTaken = 0; MEMwriteAddr = '0; MEMregWrite = 0; MEMmemtoReg = 2'b00;
        WBwriteAddr = '0; WBregWrite = 0; memBusy = 0;
    endtask

    // lw x5 in EX, add x6,x5,x1 in ID
    task automatic set_lu();
        EXmemtoReg = 2'b01; EXwriteAddr = 5'd5;
        IDuses1 = 1; IDreadAddr1 = 5'd5; IDuses2 = 1; IDreadAddr2 = 5'd1;
    endtask

    // advance one rising edge; inputs change at the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    localparam logic [4:0] CTL_NONE   = 5'b00000;
    localparam logic [4:0] CTL_STALL  = 5'b11010;
    localparam logic [4:0] CTL_FLUSH  = 5'b00110;
    localparam logic [4:0] CTL_FREEZE = 5'b00001;

    initial begin
        clr();
        reset = 1;
        set_lu();
        EXreadAddr1 = 5'd3; MEMwriteAddr = 5'd3; MEMregWrite = 1;
        tick(); tick();
        #1;
        chk_ctl("reset_ctl", CTL_NONE);
        chk("reset_fwdA", {30'd0, forwardA}, 32'd0);
        chk_cnt("reset", 0, 0);

        // 1: load-use stall, masked next cycle, detection live again after
        reset = 0; clr(); set_lu(); #1;
        chk_ctl("lu_stall", CTL_STALL);
        tick(); #1;
        chk_ctl("lu_masked", CTL_NONE);
        chk_cnt("lu1", 1, 0);
        tick(); #1;
        chk_ctl("lu_run_again", CTL_STALL);
        tick(); chk_cnt("lu2", 2, 0);
        clr(); tick();

        // 2: load to x0 never stalls
        EXmemtoReg = 2'b01; EXwriteAddr = 5'd0; IDuses1 = 1; IDreadAddr1 = 5'd0; #1;
        chk_ctl("x0_load", CTL_NONE);
        tick(); chk_cnt("x0", 2, 0);

        // 3: branch beats load-use
        clr(); set_lu(); EXbranchTaken = 1; #1;
        chk_ctl("br_vs_lu", CTL_FLUSH);
        tick(); chk_cnt("br", 2, 1);
        EXbranchTaken = 0; #1;
        chk_ctl("br_then_lu", CTL_STALL);
        tick(); chk_cnt("br_lu", 3, 1);
        clr(); tick();

        // 4: forwarding priority
        EXreadAddr1 = 5'd3; MEMwriteAddr = 5'd3; MEMregWrite = 1; MEMmemtoReg = 2'b00;
        WBwriteAddr = 5'd3; WBregWrite = 1; #1;
        chk("fwd_mem_alu", {30'd0, forwardA}, 32'd2);
        chk("fwd_B_rf", {30'd0, forwardB}, 32'd0);
        MEMmemtoReg = 2'b10; #1;
        chk("fwd_mem_pc4", {30'd0, forwardA}, 32'd3);
        MEMwriteAddr = 5'd0; #1;
        chk("fwd_wb", {30'd0, forwardA}, 32'd1);
        clr(); EXreadAddr2 = 5'd7; MEMwriteAddr = 5'd7; WBwriteAddr = 5'd7; WBregWrite = 1; #1;
        chk("fwd_B_wb_memoff", {30'd0, forwardB}, 32'd1);
        WBregWrite = 0; #1;
        chk("fwd_B_none", {30'd0, forwardB}, 32'd0);
        clr(); WBregWrite = 1; MEMregWrite = 1; #1;
        chk("fwd_x0", {30'd0, forwardA}, 32'd0);
        clr(); tick();

        // 5: memBusy holds off a pending branch
        for (int i = 0; i < 3; i++) begin
            set_lu(); EXbranchTaken = 1; memBusy = 1; #1;
            chk_ctl($sformatf("busy_%0d", i), CTL_FREEZE);
            tick();
            chk_cnt($sformatf("busy_%0d", i), 3, 1);
        end
        memBusy = 0; #1;
        chk_ctl("busy_release", CTL_FLUSH);
        tick(); chk_cnt("busy_release", 3, 2);
        clr(); tick();

        // 6a: counter wrap (3-bit counters)
        for (int i = 0; i < 5; i++) begin
            set_lu(); #1;
            chk_ctl($sformatf("wrap_stall_%0d", i), CTL_STALL);
            tick(); clr(); tick();
        end
        chk_cnt("wrap_s", 0, 2);
        EXbranchTaken = 1;
        for (int i = 0; i < 6; i++) tick();
        chk_cnt("wrap_f", 0, 0);
        clr(); tick();

        // 6b: reset during LOAD_STALL
        set_lu(); #1;
        chk_ctl("pre_rst_stall", CTL_STALL);
        tick();
        reset = 1; EXreadAddr1 = 5'd4; WBwriteAddr = 5'd4; WBregWrite = 1; #1;
        chk_ctl("rst_in_stall", CTL_NONE);
        chk("rst_fwdA", {30'd0, forwardA}, 32'd0);
        tick(); chk_cnt("rst_stall", 0, 0);
        reset = 0; #1;
        chk_ctl("post_rst_run", CTL_STALL);
        tick(); clr(); tick();

        // 6c: reset during MEM_WAIT
        EXbranchTaken = 1; memBusy = 1; tick();
        reset = 1; memBusy = 0; #1;
        chk_ctl("rst_in_wait", CTL_NONE);
        tick(); chk_cnt("rst_wait", 0, 0);
        reset = 0; clr(); #1;
        chk_ctl("post_rst_wait", CTL_NONE);
        tick(); chk_cnt("post_rst_wait", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
